pll_lock_monitor: RTL and testbench



---
 rtl/pll_lock_monitor.sv | 158 +++++++++++++++
 tb/tb_pll_lock_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: turns the asynchronous PLL lock into a debounced ready and
// downstream reset, counts lock losses, and pulses the PLL reset pin when lock
// fails to arrive within LOCK_TIMEOUT cycles.
// Optional feature: define PLLMON_LOSS_CNT_EN to implement the loss counter;
// without it loss_cnt is tied to zero but the port is kept.
module pll_lock_monitor #(
    parameter int LOCK_TIMEOUT   = 250000,
    parameter int STABLE_CYCLES  = 2500,
    parameter int PLL_RST_CYCLES = 25,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lock_in,
    output logic             pll_reset,
    output logic             rst_out,
    output logic             ready,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] loss_cnt
);

    // Counter is sized for the longest of the three timed intervals.
    localparam int MAX_AB  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLL_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RUN       = 3'd2,
        LOST      = 3'd3,
        PLL_RST   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lock_meta_q, lock_meta_d;
    logic            lock_s_q, lock_s_d;
    logic            timeout_flag_q, timeout_flag_d;

    // Two-flop synchronizer path; lock_in feeds nothing but the first stage.
    always_comb begin
        lock_meta_d = lock_in;
        lock_s_d    = lock_meta_q;
    end

    // Next-state, interval counter and sticky timeout flag.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timeout_flag_d = timeout_flag_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    // Lock arriving on the timeout cycle takes priority.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d        = PLL_RST;
                    cnt_d          = '0;
                    timeout_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    // A dropout before lock is proven is a glitch, not a loss.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = LOST;
                    cnt_d   = '0;
                end
            end
            LOST: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
            PLL_RST: begin
                // Lock is meaningless while the PLL is held in reset.
                if (cnt_q == PLLRST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, synchronizer and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            lock_meta_q    <= 1'b0;
            lock_s_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_meta_q    <= lock_meta_d;
            lock_s_q       <= lock_s_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

`ifdef PLLMON_LOSS_CNT_EN
    localparam logic [CNT_W-1:0] LOSS_MAX = '1;

    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Saturating count of RUN -> LOST transitions.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (state_q == RUN && !lock_s_q && loss_cnt_q != LOSS_MAX) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end
    end

    // Loss counter register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = '0;
`endif

    // Outputs are pure decodes of registered state.
    assign ready        = (state_q == RUN);
    assign rst_out      = !ready;
    assign pll_reset    = (state_q == PLL_RST);
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: stimulus pushes cycle-tagged expected
// output vectors, a negedge monitor pops and compares them.
module tb_pll_lock_monitor;

    localparam int LT = 20;
    localparam int SC = 8;
    localparam int PR = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lock_in = 1'b0;
    logic          pll_reset;
    logic          rst_out;
    logic          ready;
    logic          timeout_flag;
    logic [CW-1:0] loss_cnt;

    always #5 clk = ~clk;

    pll_lock_monitor #(
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .PLL_RST_CYCLES(PR),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lock_in     (lock_in),
        .pll_reset   (pll_reset),
        .rst_out     (rst_out),
        .ready       (ready),
        .timeout_flag(timeout_flag),
        .loss_cnt    (loss_cnt)
    );

    // {pll_reset, rst_out, ready, timeout_flag, loss_cnt}
    typedef struct {
        int         cyc;
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   base   = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        logic [5:0] act;
        exp_t       e;
        act = {pll_reset, rst_out, ready, timeout_flag, loss_cnt};
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s cyc %0d got pr/ro/rdy/tf/lc=%b expected %b",
                         e.name, cyc - base, act, e.exp);
            end else begin
                $display("ok   %s cyc %0d pr/ro/rdy/tf/lc=%b", e.name, cyc - base, act);
            end
        end
    end

    // Expected loss count after n losses for this build.
    function automatic int lce(int n);
`ifdef PLLMON_LOSS_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // k is counted in clock edges after the edge recorded in base.
    task automatic expect_k(int k, bit pr, bit ro, bit rdy, bit tf, int lc, string nm);
        exp_t e;
        e.cyc  = base + k;
        e.exp  = {pr, ro, rdy, tf, 2'(lc)};
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        lock_in = 1'b0;
        step(2);
        reset = 1'b0;
        base  = cyc;
        expect_k(0, 0, 1, 0, 0, 0, "reset_state");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        step(1);

        // Clean lock: ready first after edge 1+2+8.
        do_reset();
        lock_in = 1'b1;
        for (int k = 1; k <= 10; k++) expect_k(k, 0, 1, 0, 0, 0, "s1_not_ready");
        expect_k(11, 0, 0, 1, 0, 0, "s1_ready");
        expect_k(15, 0, 0, 1, 0, 0, "s1_ready_hold");
        step(15);

        // One-cycle dropout during STABLE restarts the full window.
        do_reset();
        lock_in = 1'b1;
        for (int k = 1; k <= 18; k++) expect_k(k, 0, 1, 0, 0, 0, "s2_glitch_wait");
        expect_k(19, 0, 0, 1, 0, 0, "s2_ready");
        expect_k(20, 0, 0, 1, 0, 0, "s2_ready_hold");
        step(7);
        lock_in = 1'b0;
        step(1);
        lock_in = 1'b1;
        step(12);

        // No lock: 4-cycle PLL reset pulses every 24 cycles, sticky flag.
        do_reset();
        for (int k = 1;  k <= 19; k++) expect_k(k, 0, 1, 0, 0, 0, "s3_wait");
        for (int k = 20; k <= 23; k++) expect_k(k, 1, 1, 0, 1, 0, "s3_pll_rst1");
        for (int k = 24; k <= 43; k++) expect_k(k, 0, 1, 0, 1, 0, "s3_wait2");
        for (int k = 44; k <= 47; k++) expect_k(k, 1, 1, 0, 1, 0, "s3_pll_rst2");
        expect_k(48, 0, 1, 0, 1, 0, "s3_after_rst2");
        step(48);

        // Lock seen exactly on the timeout cycle wins over the timeout.
        do_reset();
        expect_k(19, 0, 1, 0, 0, 0, "s3b_pre_timeout");
        expect_k(20, 0, 1, 0, 0, 0, "s3b_timeout_edge");
        expect_k(27, 0, 1, 0, 0, 0, "s3b_stable_end");
        expect_k(28, 0, 0, 1, 0, 0, "s3b_ready");
        step(17);
        lock_in = 1'b1;
        step(11);

        // Four losses in RUN, each relocking through a fresh STABLE window.
        do_reset();
        lock_in = 1'b1;
        step(13);
        b = 13;
        for (int i = 0; i < 4; i++) begin
            expect_k(b + 2,  0, 0, 1, 0, lce(i),     "s4_still_run");
            expect_k(b + 3,  0, 1, 0, 0, lce(i + 1), "s4_lost");
            expect_k(b + 13, 0, 1, 0, 0, lce(i + 1), "s4_relock_wait");
            expect_k(b + 14, 0, 0, 1, 0, lce(i + 1), "s4_relocked");
            lock_in = 1'b0;
            step(3);
            lock_in = 1'b1;
            step(13);
            b += 16;
        end

        // Fifth loss then timeout; reset during the 2nd PLL_RST cycle.
        expect_k(b + 3,  0, 1, 0, 0, lce(5), "s5_lost");
        expect_k(b + 24, 1, 1, 0, 1, lce(5), "s5_pll_rst1");
        expect_k(b + 25, 1, 1, 0, 1, lce(5), "s5_pll_rst2");
        expect_k(b + 26, 0, 1, 0, 0, 0,      "s5_reset_hit");
        expect_k(b + 27, 0, 1, 0, 0, 0,      "s5_after_reset");
        lock_in = 1'b0;
        step(25);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) step(1);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
